trig_stop_ctrl: RTL and testbench
=================================

TRIG_STOP_CTRL -- requirements
Module: trig_stop_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of trigger channels, minimum 1.
REQ-002 Parameter HOLDOFF_WIDTH, default 16: width of holdoff value and counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately.
REQ-005 primed  input  1  capture memory full; trigger sensitivity enabled.
REQ-006 i_trigger  input  NUM_CH  raw trigger channels.
REQ-007 i_trig_mask  input  NUM_CH  per-channel enable; 1 = channel participates.
REQ-008 i_trig_mode  input  1  0 = OR of enabled channels; 1 = AND of all enabled channels.
REQ-009 i_edge  input  1  0 = level-sensitive; 1 = rising-edge-sensitive.
REQ-010 i_holdoff  input  HOLDOFF_WIDTH  post-trigger cycles before stop.
REQ-011 i_rearm  input  1  single-cycle pulse; leave STOPPED.
REQ-012 stopped  output  1  memory writing halted.
REQ-013 triggered  output  1  high in HOLDOFF or STOPPED.
REQ-014 o_trig_ch  output  NUM_CH  qualified channels captured at trigger.
REQ-015 o_holdoff_count  output  HOLDOFF_WIDTH  current holdoff counter.
REQ-016 o_state  output  2  FSM state encoding.

Function
REQ-017 FSM states SHALL be IDLE=0, ARMED=1, HOLDOFF=2, STOPPED=3, driven on o_state.
REQ-018 trig_d SHALL register i_trigger every cycle in all states.
REQ-019 cond SHALL be i_trigger when i_edge=0, or (i_trigger AND NOT trig_d) when i_edge=1; qual = cond AND i_trig_mask.
REQ-020 hit SHALL be (qual != 0) in OR mode, or (qual == i_trig_mask) in AND mode; hit SHALL be 0 whenever i_trig_mask == 0.
REQ-021 IDLE -> ARMED when primed=1; otherwise remain IDLE.
REQ-022 ARMED -> IDLE when primed=0; else ARMED -> HOLDOFF when hit=1; primed=0 takes priority over hit.
REQ-023 On ARMED->HOLDOFF the block SHALL clear the counter to 0, latch i_holdoff into holdoff_reg, and latch qual into o_trig_ch.
REQ-024 In HOLDOFF: primed=0 -> IDLE (counter cleared); else counter == holdoff_reg -> STOPPED; else counter increments by 1.
REQ-025 The counter SHALL never exceed holdoff_reg and never wrap; holdoff_reg = all-ones is valid.
REQ-026 Latency: for trigger sampled at edge E0, stopped SHALL rise after edge E(H+1), H = latched holdoff; H=0 gives stop after E1.
REQ-027 Changes to i_holdoff after the trigger edge SHALL have no effect until the next trigger.
REQ-028 STOPPED SHALL hold regardless of primed and i_trigger until i_rearm=1.
REQ-029 STOPPED with i_rearm=1 -> ARMED if primed=1, else IDLE; counter cleared; a hit in the same cycle SHALL be ignored.
REQ-030 i_rearm outside STOPPED SHALL be ignored.
REQ-031 stopped SHALL be registered, high exactly when state = STOPPED.
REQ-032 o_trig_ch SHALL hold its value until the next trigger or reset.

Reset
REQ-033 reset=0 SHALL asynchronously force state=IDLE, counter=0, holdoff_reg=0, trig_d=0, o_trig_ch=0, stopped=0, triggered=0.
REQ-034 After reset deasserts, operation SHALL resume at the first rising clk edge; reset mid-HOLDOFF or in STOPPED SHALL discard all capture state.

Verification
REQ-035 OR/level, mask=4'b0010, H=3, primed=1, i_trigger=4'b0010 at E0 -> o_trig_ch=4'b0010, triggered after E0, stopped after E4.
REQ-036 AND/edge, mask=4'b0011: ch0 rises at E0, ch1 rises at E1 -> no trigger; both rise at E5 -> HOLDOFF after E5; H=0 -> stopped after E6.
REQ-037 mask=0, all triggers toggling 100 cycles in both modes -> state stays ARMED, stopped=0.
REQ-038 Trigger with H=10, primed dropped at count 4 -> IDLE, counter 0, stopped never asserts; i_holdoff changed to 2 at count 1 in a separate run -> stop still after E11.
REQ-039 In STOPPED, i_rearm=1 with level trigger held high -> ARMED next cycle, HOLDOFF the cycle after; i_rearm with primed=0 -> IDLE.
REQ-040 reset low asynchronously mid-HOLDOFF (between edges) -> all outputs 0 and o_state=0 before the next clk edge.

Source files
------------

// File: rtl/trig_stop_ctrl.sv
// Trigger / stop controller for a capture memory: qualifies trigger channels,
// counts a post-trigger holdoff, then halts writing until re-armed.
module trig_stop_ctrl #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned HOLDOFF_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     primed,
  input  logic [NUM_CH-1:0]        i_trigger,
  input  logic [NUM_CH-1:0]        i_trig_mask,
  input  logic                     i_trig_mode,
  input  logic                     i_edge,
  input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
  input  logic                     i_rearm,
  output logic                     stopped,
  output logic                     triggered,
  output logic [NUM_CH-1:0]        o_trig_ch,
  output logic [HOLDOFF_WIDTH-1:0] o_holdoff_count,
  output logic [1:0]               o_state
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StHoldoff = 2'd2,
    StStopped = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [NUM_CH-1:0]        trig_d_q;
  logic [NUM_CH-1:0]        trig_ch_q, trig_ch_d;
  logic [HOLDOFF_WIDTH-1:0] cnt_q, cnt_d;
  logic [HOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d;
  logic                     stopped_q, stopped_d;
  logic                     triggered_q, triggered_d;

  logic [NUM_CH-1:0] cond;
  logic [NUM_CH-1:0] qual;
  logic              hit;

  always_comb begin
    cond = i_edge ? (i_trigger & ~trig_d_q) : i_trigger;
    qual = cond & i_trig_mask;
    // An empty mask must never fire, even though qual == mask would hold in AND mode.
    hit  = (|i_trig_mask) && (i_trig_mode ? (qual == i_trig_mask) : (|qual));
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    holdoff_d = holdoff_q;
    trig_ch_d = trig_ch_q;
    case (state_q)
      StIdle: begin
        if (primed) state_d = StArmed;
      end
      StArmed: begin
        if (!primed) begin
          state_d = StIdle;
        end else if (hit) begin
          state_d   = StHoldoff;
          cnt_d     = '0;
          holdoff_d = i_holdoff;
          trig_ch_d = qual;
        end
      end
      StHoldoff: begin
        if (!primed) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == holdoff_q) begin
          state_d = StStopped;
        end else begin
          cnt_d = cnt_q + HOLDOFF_WIDTH'(1);
        end
      end
      StStopped: begin
        if (i_rearm) begin
          state_d = primed ? StArmed : StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    stopped_d   = (state_d == StStopped);
    triggered_d = (state_d == StHoldoff) || (state_d == StStopped);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      trig_d_q    <= '0;
      trig_ch_q   <= '0;
      cnt_q       <= '0;
      holdoff_q   <= '0;
      stopped_q   <= 1'b0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_d_q    <= i_trigger;
      trig_ch_q   <= trig_ch_d;
      cnt_q       <= cnt_d;
      holdoff_q   <= holdoff_d;
      stopped_q   <= stopped_d;
      triggered_q <= triggered_d;
    end
  end

  assign stopped         = stopped_q;
  assign triggered       = triggered_q;
  assign o_trig_ch       = trig_ch_q;
  assign o_holdoff_count = cnt_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_trig_stop_ctrl.sv
// Bench for trig_stop_ctrl: vector table plus hand sequences, checked via an expectation queue.
module tb_trig_stop_ctrl;

  typedef struct packed {
    logic        primed;
    logic [3:0]  trig;
    logic [3:0]  mask;
    logic        mode;
    logic        edg;
    logic [15:0] hold;
    logic        rearm;
    logic [1:0]  st;
    logic        stp;
    logic        trg;
    logic [15:0] cnt;
    logic [3:0]  ch;
  } vec_t;

  typedef struct packed {
    logic [1:0]  st;
    logic        stp;
    logic        trg;
    logic [15:0] cnt;
    logic [3:0]  ch;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        primed = 1'b0;
  logic [3:0]  i_trigger = '0;
  logic [3:0]  i_trig_mask = '0;
  logic        i_trig_mode = 1'b0;
  logic        i_edge = 1'b0;
  logic [15:0] i_holdoff = '0;
  logic        i_rearm = 1'b0;
  logic        stopped;
  logic        triggered;
  logic [3:0]  o_trig_ch;
  logic [15:0] o_holdoff_count;
  logic [1:0]  o_state;

  int n_cmp  = 0;
  int n_fail = 0;

  exp_t  exp_q[$];
  string name_q[$];
  vec_t  tbl[17];

  trig_stop_ctrl #(
    .NUM_CH       (4),
    .HOLDOFF_WIDTH(16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .primed         (primed),
    .i_trigger      (i_trigger),
    .i_trig_mask    (i_trig_mask),
    .i_trig_mode    (i_trig_mode),
    .i_edge         (i_edge),
    .i_holdoff      (i_holdoff),
    .i_rearm        (i_rearm),
    .stopped        (stopped),
    .triggered      (triggered),
    .o_trig_ch      (o_trig_ch),
    .o_holdoff_count(o_holdoff_count),
    .o_state        (o_state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic p, input logic [3:0] t, input logic [3:0] m,
                              input logic md, input logic ed, input logic [15:0] h,
                              input logic ra, input logic [1:0] st, input logic stp,
                              input logic trg, input logic [15:0] cnt, input logic [3:0] ch);
    vec_t v;
    v.primed = p;  v.trig = t;   v.mask = m;  v.mode = md; v.edg = ed; v.hold = h;
    v.rearm  = ra; v.st   = st;  v.stp  = stp; v.trg = trg; v.cnt = cnt; v.ch = ch;
    return v;
  endfunction

  task automatic compare(input string nm, input exp_t e);
    exp_t a;
    a = {o_state, stopped, triggered, o_holdoff_count, o_trig_ch};
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got st=%0d stp=%b trg=%b cnt=%0d ch=%b, want st=%0d stp=%b trg=%b cnt=%0d ch=%b",
               nm, a.st, a.stp, a.trg, a.cnt, a.ch, e.st, e.stp, e.trg, e.cnt, e.ch);
    end
  endtask

  // Drive one cycle of inputs, queue what the outputs must be after the next edge.
  task automatic step(input vec_t v, input string nm);
    exp_t e;
    primed      = v.primed;
    i_trigger   = v.trig;
    i_trig_mask = v.mask;
    i_trig_mode = v.mode;
    i_edge      = v.edg;
    i_holdoff   = v.hold;
    i_rearm     = v.rearm;
    e = {v.st, v.stp, v.trg, v.cnt, v.ch};
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0 entries, want 1", nm);
    end else begin
      compare(name_q.pop_front(), exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    // OR/level, mask 0010, H=3: trigger at E0, stop after E4.
    tbl[0]  = mk(1, 4'b0000, 4'b0010, 0, 0, 16'd3, 0, 2'd1, 0, 0, 16'd0, 4'b0000);
    tbl[1]  = mk(1, 4'b0010, 4'b0010, 0, 0, 16'd3, 0, 2'd2, 0, 1, 16'd0, 4'b0010);
    tbl[2]  = mk(1, 4'b0000, 4'b0010, 0, 0, 16'd3, 0, 2'd2, 0, 1, 16'd1, 4'b0010);
    tbl[3]  = mk(1, 4'b0000, 4'b0010, 0, 0, 16'd3, 0, 2'd2, 0, 1, 16'd2, 4'b0010);
    tbl[4]  = mk(1, 4'b0000, 4'b0010, 0, 0, 16'd3, 0, 2'd2, 0, 1, 16'd3, 4'b0010);
    tbl[5]  = mk(1, 4'b0000, 4'b0010, 0, 0, 16'd3, 0, 2'd3, 1, 1, 16'd3, 4'b0010);
    tbl[6]  = mk(0, 4'b1111, 4'b0010, 0, 0, 16'd3, 0, 2'd3, 1, 1, 16'd3, 4'b0010);
    tbl[7]  = mk(1, 4'b0000, 4'b0010, 0, 0, 16'd3, 1, 2'd1, 0, 0, 16'd0, 4'b0010);
    // AND/edge, mask 0011, H=0: staggered rises do not fire, joint rise does.
    tbl[8]  = mk(1, 4'b0001, 4'b0011, 1, 1, 16'd0, 0, 2'd1, 0, 0, 16'd0, 4'b0010);
    tbl[9]  = mk(1, 4'b0011, 4'b0011, 1, 1, 16'd0, 0, 2'd1, 0, 0, 16'd0, 4'b0010);
    tbl[10] = mk(1, 4'b0011, 4'b0011, 1, 1, 16'd0, 0, 2'd1, 0, 0, 16'd0, 4'b0010);
    tbl[11] = mk(1, 4'b0000, 4'b0011, 1, 1, 16'd0, 0, 2'd1, 0, 0, 16'd0, 4'b0010);
    tbl[12] = mk(1, 4'b0000, 4'b0011, 1, 1, 16'd0, 0, 2'd1, 0, 0, 16'd0, 4'b0010);
    tbl[13] = mk(1, 4'b0011, 4'b0011, 1, 1, 16'd0, 0, 2'd2, 0, 1, 16'd0, 4'b0011);
    tbl[14] = mk(1, 4'b0011, 4'b0011, 1, 1, 16'd0, 0, 2'd3, 1, 1, 16'd0, 4'b0011);
    tbl[15] = mk(0, 4'b0000, 4'b0011, 1, 1, 16'd0, 1, 2'd0, 0, 0, 16'd0, 4'b0011);
    tbl[16] = mk(0, 4'b0000, 4'b0011, 1, 1, 16'd0, 1, 2'd0, 0, 0, 16'd0, 4'b0011);

    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b0;
    #1 compare("reset_async", '0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 17; i++) step(tbl[i], $sformatf("tbl[%0d]", i));

    // Empty mask: random toggling in all modes never fires; stray rearm ignored.
    step(mk(1, 4'b0000, 4'b0000, 0, 0, 16'd5, 0, 2'd1, 0, 0, 16'd0, 4'b0011), "mask0_arm");
    for (int i = 0; i < 100; i++) begin
      step(mk(1, 4'($urandom), 4'b0000, 1'(i / 50), 1'(i % 2), 16'd5, 1'(i % 3 == 0),
              2'd1, 0, 0, 16'd0, 4'b0011), $sformatf("mask0[%0d]", i));
    end

    // H=10, primed dropped at count 4.
    step(mk(1, 4'b0001, 4'b0001, 0, 0, 16'd10, 0, 2'd2, 0, 1, 16'd0, 4'b0001), "drop_trig");
    for (int k = 1; k <= 4; k++) begin
      step(mk(1, 4'b0000, 4'b0001, 0, 0, 16'd10, 0, 2'd2, 0, 1, 16'(k), 4'b0001),
           $sformatf("drop_cnt%0d", k));
    end
    for (int k = 0; k < 4; k++) begin
      step(mk(0, 4'b0000, 4'b0001, 0, 0, 16'd10, 0, 2'd0, 0, 0, 16'd0, 4'b0001),
           $sformatf("drop_idle%0d", k));
    end

    // H=10 latched; i_holdoff changed to 2 at count 1 has no effect, stop after E11.
    step(mk(1, 4'b0000, 4'b0001, 0, 0, 16'd10, 0, 2'd1, 0, 0, 16'd0, 4'b0001), "hchg_arm");
    step(mk(1, 4'b0001, 4'b0001, 0, 0, 16'd10, 0, 2'd2, 0, 1, 16'd0, 4'b0001), "hchg_e0");
    step(mk(1, 4'b0000, 4'b0001, 0, 0, 16'd10, 0, 2'd2, 0, 1, 16'd1, 4'b0001), "hchg_e1");
    for (int k = 2; k <= 10; k++) begin
      step(mk(1, 4'b0000, 4'b0001, 0, 0, 16'd2, 0, 2'd2, 0, 1, 16'(k), 4'b0001),
           $sformatf("hchg_e%0d", k));
    end
    step(mk(1, 4'b0000, 4'b0001, 0, 0, 16'd2, 0, 2'd3, 1, 1, 16'd10, 4'b0001), "hchg_e11");

    // Rearm with level trigger held: same-cycle hit ignored, HOLDOFF one cycle later.
    step(mk(1, 4'b0001, 4'b0001, 0, 0, 16'd2, 1, 2'd1, 0, 0, 16'd0, 4'b0001), "rearm_arm");
    step(mk(1, 4'b0001, 4'b0001, 0, 0, 16'd2, 0, 2'd2, 0, 1, 16'd0, 4'b0001), "rearm_hold");
    step(mk(1, 4'b0000, 4'b0001, 0, 0, 16'd2, 0, 2'd2, 0, 1, 16'd1, 4'b0001), "rearm_c1");
    step(mk(1, 4'b0000, 4'b0001, 0, 0, 16'd2, 0, 2'd2, 0, 1, 16'd2, 4'b0001), "rearm_c2");
    step(mk(1, 4'b0000, 4'b0001, 0, 0, 16'd2, 0, 2'd3, 1, 1, 16'd2, 4'b0001), "rearm_stop");
    step(mk(0, 4'b0001, 4'b0001, 0, 0, 16'd2, 1, 2'd0, 0, 0, 16'd0, 4'b0001), "rearm_idle");

    // Reset asserted between edges mid-HOLDOFF.
    step(mk(1, 4'b0000, 4'b0100, 0, 0, 16'd50, 0, 2'd1, 0, 0, 16'd0, 4'b0001), "rst_arm");
    step(mk(1, 4'b0100, 4'b0100, 0, 0, 16'd50, 0, 2'd2, 0, 1, 16'd0, 4'b0100), "rst_trig");
    step(mk(1, 4'b0000, 4'b0100, 0, 0, 16'd50, 0, 2'd2, 0, 1, 16'd1, 4'b0100), "rst_c1");
    step(mk(1, 4'b0000, 4'b0100, 0, 0, 16'd50, 0, 2'd2, 0, 1, 16'd2, 4'b0100), "rst_c2");
    #2 reset = 1'b0;
    #1 compare("rst_mid_holdoff", '0);
    @(posedge clk);
    #1 compare("rst_held", '0);
    reset = 1'b1;
    step(mk(0, 4'b0000, 4'b0100, 0, 0, 16'd50, 0, 2'd0, 0, 0, 16'd0, 4'b0000), "rst_idle");
    step(mk(1, 4'b0000, 4'b0100, 0, 0, 16'd50, 0, 2'd1, 0, 0, 16'd0, 4'b0000), "rst_rearm");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
